// File: rtl/p1_sprite_renderer_if.sv
// Signal bundle between the VGA timing/game logic, the sprite ROM and the player renderer.
// The renderer takes the slave side; the surrounding system takes the master side.
interface p1_sprite_renderer_if;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        video_on;
    logic        frame_tick;
    logic [9:0]  p1_x;
    logic [9:0]  p1_y;
    logic [2:0]  action;
    logic        facing;
    logic [9:0]  rom_addr;
    logic [15:0] rom_bitmap;
    logic        sprite_on;
    logic        pix_valid;
    logic        action_done;

    modport slave (
        input  pixel_x, pixel_y, video_on, frame_tick,
        input  p1_x, p1_y, action, facing, rom_bitmap,
        output rom_addr, sprite_on, pix_valid, action_done
    );

    modport master (
        output pixel_x, pixel_y, video_on, frame_tick,
        output p1_x, p1_y, action, facing, rom_bitmap,
        input  rom_addr, sprite_on, pix_valid, action_done
    );
endinterface

// File: rtl/p1_sprite_renderer.sv
// Player-1 sprite renderer: per-frame shadowed position/animation state and a 3-stage
// pixel pipeline that looks up a 16x16 sprite row in ROM and flags opaque pixels.
module p1_sprite_renderer #(
    parameter int SCALE_LOG2 = 2,
    parameter int HOLD       = 8
) (
    input logic clk,
    input logic rst,
    p1_sprite_renderer_if.slave bus
);
    localparam int          W   = 16 << SCALE_LOG2;
    localparam int          HW  = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [10:0] BOX = 11'(W);

    function automatic logic [2:0] map_action(input logic [2:0] a);
        return (a > 3'd4) ? 3'd0 : a;
    endfunction

    function automatic logic [3:0] mirror_col(input logic [3:0] c, input logic m);
        return m ? (4'd15 - c) : c;
    endfunction

    logic [9:0]    sx, sy;
    logic [2:0]    act_sh;
    logic          fac_sh;
    logic [1:0]    frame;
    logic [HW-1:0] hold;
    logic          done_r;
    logic [2:0]    act_new;

    assign act_new = map_action(bus.action);

    always_ff @(posedge clk) begin
        if (rst) begin
            sx     <= '0;
            sy     <= '0;
            act_sh <= '0;
            fac_sh <= 1'b0;
            frame  <= '0;
            hold   <= '0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (bus.frame_tick) begin
                sx     <= bus.p1_x;
                sy     <= bus.p1_y;
                act_sh <= act_new;
                fac_sh <= bus.facing;
                // A new action restarts its animation from the first frame.
                if (act_new != act_sh) begin
                    frame <= '0;
                    hold  <= '0;
                end else if (hold == HW'(HOLD - 1)) begin
                    hold  <= '0;
                    frame <= frame + 2'd1;
                    if (frame == 2'd3 && (act_sh == 3'd3 || act_sh == 3'd4))
                        done_r <= 1'b1;
                end else begin
                    hold <= hold + 1'b1;
                end
            end
        end
    end

    logic [10:0] px, py, x0, y0;
    logic [9:0]  dx, dy;
    logic        in_box;
    logic [3:0]  row, col;

    assign px     = {1'b0, bus.pixel_x};
    assign py     = {1'b0, bus.pixel_y};
    assign x0     = {1'b0, sx};
    assign y0     = {1'b0, sy};
    // 11-bit bounds keep a box near the right/bottom edge from wrapping to column/row 0.
    assign in_box = (px >= x0) && (px < x0 + BOX) && (py >= y0) && (py < y0 + BOX);
    assign dx     = bus.pixel_x - sx;
    assign dy     = bus.pixel_y - sy;
    assign row    = 4'(dy >> SCALE_LOG2);
    assign col    = mirror_col(4'(dx >> SCALE_LOG2), fac_sh);

    logic [9:0] addr_p0;
    logic [3:0] col_p0, col_p1;
    logic       box_p0, box_p1;
    logic       vld_p0, vld_p1, vld_p2;
    logic       sprite_p2;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_p0   <= '0;
            col_p0    <= '0;
            box_p0    <= 1'b0;
            vld_p0    <= 1'b0;
            col_p1    <= '0;
            box_p1    <= 1'b0;
            vld_p1    <= 1'b0;
            sprite_p2 <= 1'b0;
            vld_p2    <= 1'b0;
        end else begin
            // Stage 1: box test and ROM address; address holds outside the box.
            if (in_box)
                addr_p0 <= {row, act_sh, 1'b0, frame};
            col_p0 <= col;
            box_p0 <= in_box;
            vld_p0 <= bus.video_on;
            // Stage 2: wait for the ROM row to arrive.
            col_p1 <= col_p0;
            box_p1 <= box_p0;
            vld_p1 <= vld_p0;
            // Stage 3: pick the column bit; a 0 bit is opaque.
            sprite_p2 <= vld_p1 & box_p1 & ~bus.rom_bitmap[4'd15 - col_p1];
            vld_p2    <= vld_p1;
        end
    end

    assign bus.rom_addr    = addr_p0;
    assign bus.sprite_on   = sprite_p2;
    assign bus.pix_valid   = vld_p2;
    assign bus.action_done = done_r;
endmodule

// File: tb/tb_p1_sprite_renderer.sv
// Bench for p1_sprite_renderer: behavioural ROM, reference model of shadow/animation state,
// and a latency-tagged queue of expected pixel outputs.
module tb_p1_sprite_renderer;
    localparam int SCALE_LOG2 = 2;
    localparam int HOLD       = 8;
    localparam int SC         = 1 << SCALE_LOG2;
    localparam int W          = 16 * SC;

    typedef struct {int x; int y; logic von;} pix_t;
    typedef struct {logic so; logic pv; int due;} exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    p1_sprite_renderer_if bus();

    p1_sprite_renderer #(.SCALE_LOG2(SCALE_LOG2), .HOLD(HOLD)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rom_data(input logic [9:0] a);
        return 16'hFC3F ^ {a[5:0], 1'b0, a[9:6], 5'b0};
    endfunction

    always @(posedge clk) bus.rom_bitmap <= rom_data(bus.rom_addr);

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int m_sx = 0, m_sy = 0, m_act = 0, m_fac = 0, m_frame = 0, m_hold = 0;
    logic [9:0] m_addr = '0;
    exp_t q[$];

    function automatic pix_t mk(input int x, input int y, input logic v);
        pix_t p;
        p.x = x; p.y = y; p.von = v;
        return p;
    endfunction

    function automatic logic m_inbox(input int x, input int y);
        return (x >= m_sx) && (x < m_sx + W) && (y >= m_sy) && (y < m_sy + W);
    endfunction

    function automatic logic [9:0] m_addr_of(input int x, input int y);
        int row;
        row = (y - m_sy) / SC;
        return {4'(row), 3'(m_act), 1'b0, 2'(m_frame)};
    endfunction

    function automatic logic m_sprite(input int x, input int y, input logic von);
        int col;
        logic [15:0] d;
        if (!von || !m_inbox(x, y)) return 1'b0;
        col = (x - m_sx) / SC;
        if (m_fac != 0) col = 15 - col;
        d = rom_data(m_addr_of(x, y));
        return ~d[15 - col];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic model_capture(input int x, input int y, input int a, input int f, output logic expd);
        int an;
        an = (a > 4) ? 0 : a;
        expd = 1'b0;
        if (an != m_act) begin
            m_frame = 0; m_hold = 0;
        end else if (m_hold == HOLD - 1) begin
            m_hold = 0;
            expd = (m_frame == 3) && (m_act == 3 || m_act == 4);
            m_frame = (m_frame + 1) % 4;
        end else begin
            m_hold++;
        end
        m_sx = x; m_sy = y; m_act = an; m_fac = f;
    endtask

    task automatic model_reset();
        m_sx = 0; m_sy = 0; m_act = 0; m_fac = 0; m_frame = 0; m_hold = 0;
        m_addr = '0;
        q.delete();
    endtask

    // One capture cycle outside the visible area; returns observed and modelled action_done.
    task automatic frame_pulse(input int x, input int y, input int a, input int f,
                               output logic seen, output logic expd);
        bus.p1_x = 10'(x); bus.p1_y = 10'(y); bus.action = 3'(a); bus.facing = (f != 0);
        bus.frame_tick = 1'b1; bus.video_on = 1'b0;
        bus.pixel_x = 10'd1023; bus.pixel_y = 10'd1023;
        model_capture(x, y, a, f, expd);
        tick();
        bus.frame_tick = 1'b0;
        seen = bus.action_done;
    endtask

    task automatic probe();
        logic [9:0] a;
        a = m_addr_of(m_sx, m_sy);
        bus.pixel_x = 10'(m_sx); bus.pixel_y = 10'(m_sy); bus.video_on = 1'b0;
        tick();
        m_addr = a;
    endtask

    task automatic test_reset();
        bus.pixel_x = 10'd5; bus.pixel_y = 10'd7; bus.video_on = 1'b1; bus.frame_tick = 1'b1;
        bus.p1_x = 10'd3; bus.p1_y = 10'd4; bus.action = 3'd3; bus.facing = 1'b1;
        rst = 1'b1;
        tick(); tick();
        n_cmp++;
        if ({bus.rom_addr, bus.sprite_on, bus.pix_valid, bus.action_done} !== 13'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got addr=%0o so=%b pv=%b done=%b want all 0",
                     bus.rom_addr, bus.sprite_on, bus.pix_valid, bus.action_done);
        end
        bus.frame_tick = 1'b0; bus.video_on = 1'b0;
        rst = 1'b0;
        model_reset();
        bus.pixel_x = 10'd1023; bus.pixel_y = 10'd1023;
        tick();
    endtask

    task automatic test_render();
        pix_t stim[$];
        exp_t e;
        logic inb, seen, expd;
        logic [9:0] a;
        for (int ph = 0; ph < 3; ph++) begin
            stim.delete();
            if (ph == 0) begin
                frame_pulse(100, 200, 0, 0, seen, expd);
                stim.push_back(mk(100, 200, 1'b1)); stim.push_back(mk(124, 200, 1'b1));
                stim.push_back(mk(164, 200, 1'b1)); stim.push_back(mk(99, 200, 1'b1));
                stim.push_back(mk(163, 263, 1'b1)); stim.push_back(mk(163, 264, 1'b1));
            end else if (ph == 1) begin
                frame_pulse(100, 200, 0, 1, seen, expd);
                stim.push_back(mk(100, 228, 1'b1)); stim.push_back(mk(120, 228, 1'b1));
            end else begin
                frame_pulse(630, 200, 0, 0, seen, expd);
                for (int x = 624; x < 640; x++) stim.push_back(mk(x, 200, 1'b1));
                for (int x = 0; x < 4; x++) stim.push_back(mk(x, 200, 1'b1));
                stim.push_back(mk(635, 263, 1'b1)); stim.push_back(mk(635, 264, 1'b1));
            end
            if (ph < 2)
                for (int i = 0; i < 40; i++)
                    stim.push_back(mk($urandom_range(175, 90), $urandom_range(270, 190),
                                      $urandom_range(7, 0) != 0));
            for (int i = 0; i < stim.size() + 3; i++) begin
                inb = 1'b0; a = '0;
                if (i < stim.size()) begin
                    bus.pixel_x = 10'(stim[i].x); bus.pixel_y = 10'(stim[i].y);
                    bus.video_on = stim[i].von;
                    inb = m_inbox(stim[i].x, stim[i].y);
                    a = m_addr_of(stim[i].x, stim[i].y);
                    e.so = m_sprite(stim[i].x, stim[i].y, stim[i].von);
                    e.pv = stim[i].von; e.due = cyc + 4;
                    q.push_back(e);
                end else begin
                    bus.pixel_x = 10'd1023; bus.pixel_y = 10'd1023; bus.video_on = 1'b0;
                end
                tick();
                if (inb) m_addr = a;
                n_cmp++;
                if (bus.rom_addr !== m_addr) begin
                    n_bad++;
                    $display("FAIL render_rom_addr ph%0d i%0d: got %0o want %0o", ph, i, bus.rom_addr, m_addr);
                end
                while (q.size() > 0 && q[0].due == cyc + 1) begin
                    e = q.pop_front();
                    n_cmp++;
                    if ({bus.sprite_on, bus.pix_valid} !== {e.so, e.pv}) begin
                        n_bad++;
                        $display("FAIL render_pixel ph%0d i%0d: got so/pv=%b%b want %b%b",
                                 ph, i, bus.sprite_on, bus.pix_valid, e.so, e.pv);
                    end
                end
            end
            n_cmp++;
            if (q.size() != 0) begin
                n_bad++;
                $display("FAIL render_drain ph%0d: got %0d pending want 0", ph, q.size());
                q.delete();
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic inb, expd, seen;
        logic [9:0] a;
        frame_pulse(100, 200, 0, 0, seen, expd);
        for (int i = 0; i < 43; i++) begin
            inb = 1'b0; a = '0;
            if (i < 40) begin
                bus.pixel_x = 10'(96 + 2 * i); bus.pixel_y = 10'd204; bus.video_on = 1'b1;
                inb = m_inbox(96 + 2 * i, 204);
                a = m_addr_of(96 + 2 * i, 204);
                e.so = m_sprite(96 + 2 * i, 204, 1'b1); e.pv = 1'b1; e.due = cyc + 4;
                q.push_back(e);
                if (i == 20) begin
                    bus.frame_tick = 1'b1; bus.p1_x = 10'd120; bus.p1_y = 10'd200;
                    bus.action = 3'd0; bus.facing = 1'b1;
                    model_capture(120, 200, 0, 1, expd);
                end
            end else begin
                bus.pixel_x = 10'd1023; bus.pixel_y = 10'd1023; bus.video_on = 1'b0;
            end
            tick();
            bus.frame_tick = 1'b0;
            if (inb) m_addr = a;
            n_cmp++;
            if (bus.rom_addr !== m_addr) begin
                n_bad++;
                $display("FAIL b2b_rom_addr i%0d: got %0o want %0o", i, bus.rom_addr, m_addr);
            end
            while (q.size() > 0 && q[0].due == cyc + 1) begin
                e = q.pop_front();
                n_cmp++;
                if ({bus.sprite_on, bus.pix_valid} !== {e.so, e.pv}) begin
                    n_bad++;
                    $display("FAIL b2b_pixel i%0d: got so/pv=%b%b want %b%b",
                             i, bus.sprite_on, bus.pix_valid, e.so, e.pv);
                end
            end
        end
    endtask

    task automatic test_animation();
        logic seen, expd;
        int pulses;
        frame_pulse(100, 200, 3, 0, seen, expd);
        probe();
        n_cmp++;
        if (bus.rom_addr !== {4'd0, 3'd3, 1'b0, 2'd0}) begin
            n_bad++;
            $display("FAIL anim_start: got %0o want %0o", bus.rom_addr, {4'd0, 3'd3, 1'b0, 2'd0});
        end
        pulses = 0;
        for (int t = 1; t <= 32; t++) begin
            frame_pulse(100, 200, 3, 0, seen, expd);
            if (seen === 1'b1) pulses++;
            n_cmp++;
            if (seen !== (t == 32)) begin
                n_bad++;
                $display("FAIL anim_done t%0d: got %b want %b", t, seen, (t == 32));
            end
            probe();
            n_cmp++;
            if (bus.rom_addr !== {4'd0, 3'd3, 1'b0, 2'((t / 8) % 4)} || bus.action_done !== 1'b0) begin
                n_bad++;
                $display("FAIL anim_frame t%0d: got addr=%0o done=%b want addr=%0o done=0",
                         t, bus.rom_addr, bus.action_done, {4'd0, 3'd3, 1'b0, 2'((t / 8) % 4)});
            end
        end
        n_cmp++;
        if (pulses != 1) begin
            n_bad++;
            $display("FAIL anim_punch_pulses: got %0d want 1", pulses);
        end
        frame_pulse(100, 200, 0, 0, seen, expd);
        pulses = 0;
        for (int t = 1; t <= 32; t++) begin
            frame_pulse(100, 200, 0, 0, seen, expd);
            if (seen === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses != 0) begin
            n_bad++;
            $display("FAIL anim_stay_pulses: got %0d want 0", pulses);
        end
    endtask

    task automatic test_action_change();
        logic seen, expd;
        frame_pulse(100, 200, 1, 0, seen, expd);
        repeat (16) frame_pulse(100, 200, 1, 0, seen, expd);
        probe();
        n_cmp++;
        if (bus.rom_addr !== {4'd0, 3'd1, 1'b0, 2'd2}) begin
            n_bad++;
            $display("FAIL change_pre: got %0o want %0o", bus.rom_addr, {4'd0, 3'd1, 1'b0, 2'd2});
        end
        frame_pulse(100, 200, 4, 0, seen, expd);
        probe();
        n_cmp++;
        if (bus.rom_addr !== {4'd0, 3'd4, 1'b0, 2'd0}) begin
            n_bad++;
            $display("FAIL change_to_kick: got %0o want %0o", bus.rom_addr, {4'd0, 3'd4, 1'b0, 2'd0});
        end
        repeat (7) frame_pulse(100, 200, 4, 0, seen, expd);
        probe();
        n_cmp++;
        if (bus.rom_addr !== {4'd0, 3'd4, 1'b0, 2'd0}) begin
            n_bad++;
            $display("FAIL change_hold7: got %0o want %0o", bus.rom_addr, {4'd0, 3'd4, 1'b0, 2'd0});
        end
        frame_pulse(100, 200, 4, 0, seen, expd);
        probe();
        n_cmp++;
        if (bus.rom_addr !== {4'd0, 3'd4, 1'b0, 2'd1}) begin
            n_bad++;
            $display("FAIL change_hold8: got %0o want %0o", bus.rom_addr, {4'd0, 3'd4, 1'b0, 2'd1});
        end
        frame_pulse(100, 200, 6, 0, seen, expd);
        probe();
        n_cmp++;
        if (bus.rom_addr !== 10'd0) begin
            n_bad++;
            $display("FAIL change_code6: got %0o want 0", bus.rom_addr);
        end
    endtask

    task automatic test_reset_mid_line();
        logic seen, expd;
        repeat (9) frame_pulse(100, 200, 2, 0, seen, expd);
        bus.pixel_x = 10'd124; bus.pixel_y = 10'd200; bus.video_on = 1'b1;
        repeat (4) tick();
        n_cmp++;
        if (bus.sprite_on !== 1'b1 || bus.pix_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL midline_before: got so/pv=%b%b want 11", bus.sprite_on, bus.pix_valid);
        end
        rst = 1'b1;
        tick();
        n_cmp++;
        if ({bus.rom_addr, bus.sprite_on, bus.pix_valid, bus.action_done} !== 13'd0) begin
            n_bad++;
            $display("FAIL midline_reset: got addr=%0o so=%b pv=%b done=%b want all 0",
                     bus.rom_addr, bus.sprite_on, bus.pix_valid, bus.action_done);
        end
        rst = 1'b0;
        model_reset();
        bus.pixel_x = 10'd24; bus.pixel_y = 10'd0; bus.video_on = 1'b1;
        tick();
        bus.pixel_x = 10'd1023; bus.pixel_y = 10'd1023; bus.video_on = 1'b0;
        n_cmp++;
        if (bus.rom_addr !== 10'd0 || bus.pix_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL post_reset_c1: got addr=%0o pv=%b want addr=0 pv=0", bus.rom_addr, bus.pix_valid);
        end
        tick();
        n_cmp++;
        if (bus.pix_valid !== 1'b0 || bus.sprite_on !== 1'b0) begin
            n_bad++;
            $display("FAIL post_reset_c2: got so/pv=%b%b want 00", bus.sprite_on, bus.pix_valid);
        end
        tick();
        n_cmp++;
        if (bus.pix_valid !== 1'b1 || bus.sprite_on !== 1'b1) begin
            n_bad++;
            $display("FAIL post_reset_c3: got so/pv=%b%b want 11", bus.sprite_on, bus.pix_valid);
        end
    endtask

    initial begin
        bus.pixel_x = '0; bus.pixel_y = '0; bus.video_on = 1'b0; bus.frame_tick = 1'b0;
        bus.p1_x = '0; bus.p1_y = '0; bus.action = '0; bus.facing = 1'b0;
        test_reset();
        test_render();
        test_back_to_back();
        test_animation();
        test_action_change();
        test_reset_mid_line();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout: got no finish within 40000 cycles want finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/p1_sprite_renderer.md
P1_SPRITE_RENDERER -- requirements
Module: p1_sprite_renderer

Interface
REQ-001 Parameter SCALE_LOG2, default 2, on-screen magnification of the 16x16 sprite (box width/height W = 16<<SCALE_LOG2).
REQ-002 Parameter HOLD, default 8, number of frame_tick pulses each animation frame is held.
REQ-003 clk  in  1  system/pixel clock; the only clock; all state updates on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 pixel_x  in  10  current scan column from the VGA timing block.
REQ-006 pixel_y  in  10  current scan row.
REQ-007 video_on  in  1  high while pixel_x/pixel_y lie in the visible area.
REQ-008 frame_tick  in  1  one-cycle pulse per video frame, during vertical blanking.
REQ-009 p1_x, p1_y  in  10 each  top-left screen position of the player box.
REQ-010 action  in  3  0 stay, 1 forward, 2 backward, 3 punch, 4 kick; codes 5-7 are treated as 0.
REQ-011 facing  in  1  0 = unmirrored, 1 = horizontally mirrored.
REQ-012 rom_addr  out  10  sprite ROM address {row[3:0], action[2:0], frame[2:0]}.
REQ-013 rom_bitmap  in  16  ROM row data, valid one cycle after rom_addr; bit 15 = leftmost column; 0 = opaque, 1 = transparent.
REQ-014 sprite_on  out  1  high when the current pipelined pixel is an opaque player pixel.
REQ-015 pix_valid  out  1  video_on delayed to align with sprite_on.
REQ-016 action_done  out  1  one-cycle pulse when a punch or kick animation completes.

Function
REQ-017 On frame_tick, shadow registers capture p1_x, p1_y, action (5-7 mapped to 0) and facing; rendering uses only shadow values, so no mid-frame tearing.
REQ-018 A hold counter (0..HOLD-1) increments on each frame_tick; when it wraps to 0, frame (0..3) increments mod 4.
REQ-019 If the action captured on a frame_tick differs from the previous shadow action, frame and hold counter are set to 0 on that edge.
REQ-020 action_done pulses for one cycle on the edge where frame wraps 3->0 while the shadow action is 3 or 4; never for actions 0-2.
REQ-021 Stage 1 (edge after inputs sampled): in_box = pixel_x in [sx, sx+W) and pixel_y in [sy, sy+W), computed with 11-bit unsigned compares (no wrap; boxes past 639/479 clip).
REQ-022 Stage 1: row = (pixel_y-sy)>>SCALE_LOG2, col = (pixel_x-sx)>>SCALE_LOG2; if facing=1, col = 15-col.
REQ-023 Stage 1: rom_addr is registered as {row, shadow action, 0, frame[1:0]}; it holds its last value when in_box=0.
REQ-024 Stage 2: col, in_box and video_on are delayed one further cycle to align with rom_bitmap.
REQ-025 Stage 3: sprite_on <= video_on_d2 & in_box_d2 & ~rom_bitmap[15-col_d2]; pix_valid <= video_on_d2.
REQ-026 Total latency pixel_x/pixel_y -> sprite_on/pix_valid is exactly 3 cycles; throughput one pixel per cycle, no stalls.
REQ-027 frame_tick coincident with visible pixels affects only pixels sampled after the capture edge.

Reset
REQ-028 While rst=1: rom_addr=0, sprite_on=0, pix_valid=0, action_done=0, frame=0, hold counter=0, all shadow registers and pipeline registers 0.
REQ-029 Reset asserted mid-animation or mid-line discards pipeline contents; the first valid output appears 3 cycles after the first post-reset sampled pixel.

Verification
REQ-030 Shadow p1=(100,200), action 0, facing 0, SCALE_LOG2=2; pixel (100,200) -> rom_addr=10'o0000 after 1 cycle, sprite_on=0 after 3 cycles (bit15 of 1111110000111111 is 1); pixel (124,200) -> sprite_on=1.
REQ-031 Same setup, facing=1, pixel (100,228) (row 7, col 0 mirrored to 15): rom_addr=10'o0700, sprite_on = ~bit0 = 0; pixel (120,228) -> col 10 -> sprite_on=1.
REQ-032 Pixel (164,200) and (99,200) -> sprite_on=0 (outside box); p1_x=630 -> pixels 630..639 render, no wrap to column 0.
REQ-033 Action 3 held, HOLD=8: after 32 frame_ticks frame sequence 0,1,2,3 each for 8 ticks and action_done pulses exactly once on the 3->0 wrap; action 0 for 32 ticks -> no pulse.
REQ-034 Change action 1->4 at frame 2 -> frame=0 and hold=0 on that capture edge; rom_addr action field=4.
REQ-035 Assert rst for one cycle mid-line with sprite_on=1 -> sprite_on, pix_valid, rom_addr all 0 on the next cycle; frame=0.
